// File: rtl/slowsym_pacer.sv
// Sample pacer for the slow symmetric filter: buffers bursty valid/ready input in a
// small FIFO and re-emits samples as o_ce strobes spaced by at least GAP idle cycles.
// Optional: define SLOWSYM_PACER_OVERFLOW_EN to add the sticky o_overflow output.
module slowsym_pacer #(
  parameter int IW     = 16,
  parameter int LGFIFO = 3,
  parameter int GAP    = 7
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [IW-1:0]     i_sample,
  output logic              o_ce,
  output logic [IW-1:0]     o_sample,
`ifdef SLOWSYM_PACER_OVERFLOW_EN
  output logic              o_overflow,
`endif
  output logic [LGFIFO:0]   o_fill
);

  localparam int unsigned   DEPTH = 1 << LGFIFO;
  localparam logic [LGFIFO:0] FULL = {1'b1, {LGFIFO{1'b0}}};
  localparam logic [7:0]    GAP_W = 8'(GAP);

  logic [IW-1:0]     mem [0:DEPTH-1];
  logic [LGFIFO-1:0] wr_ptr;
  logic [LGFIFO-1:0] rd_ptr;
  logic [7:0]        wait_cnt;
  logic              wr_en;
  logic              issue;

  assign o_ready = (o_fill != FULL);
  assign wr_en   = i_valid && o_ready;
  assign issue   = (o_fill != '0) && (wait_cnt == '0);

  // Storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr] <= i_sample;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (issue)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_fill <= '0;
    end else if (wr_en && !issue) begin
      o_fill <= o_fill + 1'b1;
    end else if (issue && !wr_en) begin
      o_fill <= o_fill - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ce     <= 1'b0;
      o_sample <= '0;
      wait_cnt <= '0;
    end else if (issue) begin
      o_ce     <= 1'b1;
      o_sample <= mem[rd_ptr];
      wait_cnt <= GAP_W;
    end else begin
      o_ce <= 1'b0;
      if (wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

`ifdef SLOWSYM_PACER_OVERFLOW_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      o_overflow <= 1'b0;
    else if (i_valid && !o_ready)
      o_overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_slowsym_pacer.sv
// Randomised scoreboard bench for slowsym_pacer against a queue-based reference model.
module tb_slowsym_pacer;
  localparam int IW     = 16;
  localparam int LGFIFO = 3;
  localparam int GAP    = 7;
  localparam int DEPTH  = 1 << LGFIFO;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [IW-1:0]     i_sample = '0;
  logic              o_ce;
  logic [IW-1:0]     o_sample;
  logic [LGFIFO:0]   o_fill;
`ifdef SLOWSYM_PACER_OVERFLOW_EN
  logic              o_overflow;
`endif

  slowsym_pacer #(.IW(IW), .LGFIFO(LGFIFO), .GAP(GAP)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_sample  (i_sample),
    .o_ce      (o_ce),
    .o_sample  (o_sample),
`ifdef SLOWSYM_PACER_OVERFLOW_EN
    .o_overflow(o_overflow),
`endif
    .o_fill    (o_fill)
  );

  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue; issue allowed once GAP+1 edges have passed.
  logic [IW-1:0] mq[$];
  logic [IW-1:0] sb_q[$];
  int            cyc = 0;
  int            last_iss = -1000;
  logic [IW-1:0] last_out = '0;
  bit            exp_ce = 0;
  bit            acc = 0;
  bit            m_ovf = 0;

  always @(posedge i_clk) begin
    bit m_ready;
    bit iss;
    cyc++;
    if (!i_reset) begin
      m_ready = (mq.size() < DEPTH);
      acc = i_valid && m_ready;
      iss = (mq.size() > 0) && ((cyc - last_iss) >= GAP + 1);
      if (i_valid && !m_ready)
        m_ovf = 1;
      if (iss) begin
        last_out = mq.pop_front();
        last_iss = cyc;
      end
      if (acc) begin
        mq.push_back(i_sample);
        sb_q.push_back(i_sample);
      end
      exp_ce = iss;
    end
  end

  // Monitor: compares timing/occupancy each cycle, pops scoreboard on every strobe.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      chk("ce", 32'(o_ce), 32'(exp_ce));
      chk("fill", 32'(o_fill), 32'(mq.size()));
      chk("ready", 32'(o_ready), 32'(mq.size() < DEPTH));
`ifdef SLOWSYM_PACER_OVERFLOW_EN
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
`endif
      if (o_ce) begin
        if (sb_q.size() == 0)
          chk("sb_underflow", 32'(o_sample), 32'hFFFF_FFFF);
        else
          chk("sample", 32'(o_sample), 32'(sb_q.pop_front()));
      end else begin
        chk("sample_hold", 32'(o_sample), 32'(last_out));
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic model_reset();
    mq.delete();
    sb_q.delete();
    last_iss = cyc - 1000;
    last_out = '0;
    exp_ce   = 0;
    acc      = 0;
    m_ovf    = 0;
  endtask

  initial begin
    int cnt;
    int n;
    int guard;
    #1 i_reset = 1'b1;
    #1;
    chk("rst_ce", 32'(o_ce), 32'd0);
    chk("rst_fill", 32'(o_fill), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_sample", 32'(o_sample), 32'd0);
    step();
    step();
    i_reset = 1'b0;

    // Single sample
    i_valid = 1'b1; i_sample = 16'h1234;
    step();
    i_valid = 1'b0;
    repeat (12) step();

    // Burst of four back-to-back samples
    for (int i = 1; i <= 4; i++) begin
      i_valid = 1'b1; i_sample = 16'(i);
      step();
    end
    i_valid = 1'b0;
    repeat (40) step();

    // Full FIFO: hold valid with an incrementing count for 100 samples
    cnt = 16'h100; n = 0; guard = 0;
    i_valid = 1'b1; i_sample = 16'(cnt);
    while (n < 100 && guard < 2000) begin
      step();
      guard++;
      if (acc) begin
        n++; cnt++;
        i_sample = 16'(cnt);
      end
    end
    i_valid = 1'b0;
    chk("full_count", 32'(n), 32'd100);
`ifdef SLOWSYM_PACER_OVERFLOW_EN
    chk("overflow_sticky", 32'(o_overflow), 32'd1);
`endif
    repeat (80) step();

    // Simultaneous read/write at fill 3
    cnt = 16'h500; guard = 0;
    while (mq.size() < 3 && guard < 100) begin
      i_valid = 1'b1; i_sample = 16'(cnt);
      step();
      guard++;
      if (acc) cnt++;
    end
    chk("simul_prefill", 32'(mq.size()), 32'd3);
    for (int i = 0; i < 40; i++) begin
      i_valid = ((cyc + 1 - last_iss) >= GAP + 1);
      i_sample = 16'(cnt);
      step();
      if (acc) cnt++;
      chk("simul_fill", 32'(o_fill), 32'd3);
    end
    i_valid = 1'b0;
    repeat (40) step();

    // Random traffic, holding data until accepted
    for (int i = 0; i < 500; i++) begin
      if (!(i_valid && !acc)) begin
        i_valid = ($urandom_range(0, 2) != 0);
        i_sample = 16'($urandom);
      end
      step();
    end
    i_valid = 1'b0;
    repeat (80) step();

    // Async reset with fill=5 and wait=4
    cnt = 16'h900; guard = 0;
    i_valid = 1'b0;
    while (!(mq.size() == 5 && (cyc - last_iss) == 3) && guard < 200) begin
      if (acc) cnt++;
      i_valid = (mq.size() < 5);
      i_sample = 16'(cnt);
      step();
      guard++;
    end
    i_valid = 1'b0;
    chk("prereset_fill", 32'(o_fill), 32'd5);
    i_reset = 1'b1;
    model_reset();
    #1;
    chk("async_ce", 32'(o_ce), 32'd0);
    chk("async_fill", 32'(o_fill), 32'd0);
    chk("async_ready", 32'(o_ready), 32'd1);
`ifdef SLOWSYM_PACER_OVERFLOW_EN
    chk("async_ovf", 32'(o_overflow), 32'd0);
`endif
    step();
    i_reset = 1'b0;
    i_valid = 1'b1; i_sample = 16'hBEEF;
    step();
    i_valid = 1'b0;
    step();
    chk("post_reset_ce", 32'(o_ce), 32'd1);
    chk("post_reset_sample", 32'(o_sample), 32'hBEEF);
    repeat (40) step();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
